time_nmr_end: RTL and testbench



---
 rtl/time_nmr_end.sv | 173 +++++++++++++++++
 tb/tb_time_nmr_end.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_nmr_end.sv
// rtl/time_nmr_end.sv - time-redundancy end stage: groups replicas by ID, votes (DMR/TMR), counts faults
module time_nmr_end #(
  parameter type         DataType     = logic,
  parameter int unsigned IDSize       = 1,
  parameter int unsigned LockTimeout  = 4,
  parameter int unsigned CounterWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              mode_i,
  input  DataType                 data_i,
  input  logic [IDSize-1:0]       id_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output DataType                 data_o,
  output logic [IDSize-1:0]       id_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    error_o,
  output logic                    lock_o,
  output logic                    fault_detected_o,
  output logic [CounterWidth-1:0] fault_count_o,
  input  logic                    fault_count_clear_i
);

  localparam int unsigned WdW = $clog2(LockTimeout + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_e;

  state_e            state_q, state_d;
  DataType           slot_q [3];
  logic [IDSize-1:0] grp_id_q;
  logic [1:0]        cnt_q;
  logic [1:0]        mode_q;
  logic [WdW-1:0]    wd_q;
  logic              voted_q;

  logic              tmr_q;
  logic [1:0]        n_req;
  logic              id_match;
  logic              wd_expire;
  DataType           vote_data;
  logic              vote_err;
  logic              vote_fault;

  assign tmr_q     = (mode_q != 2'd1);
  assign n_req     = tmr_q ? 2'd3 : 2'd2;
  assign id_match  = (id_i == grp_id_q);
  assign wd_expire = (wd_q == WdW'(LockTimeout - 1));

  // A TMR group closed with only two matching copies is still a fault: a replica went missing.
  always_comb begin
    vote_data  = slot_q[0];
    vote_err   = 1'b0;
    vote_fault = 1'b0;
    case (cnt_q)
      2'd3: begin
        if (slot_q[0] == slot_q[1] && slot_q[0] == slot_q[2]) begin
          vote_data = slot_q[0];
        end else if (slot_q[0] == slot_q[1] || slot_q[0] == slot_q[2]) begin
          vote_data  = slot_q[0];
          vote_fault = 1'b1;
        end else if (slot_q[1] == slot_q[2]) begin
          vote_data  = slot_q[1];
          vote_fault = 1'b1;
        end else begin
          vote_err   = 1'b1;
          vote_fault = 1'b1;
        end
      end
      2'd2: begin
        vote_err   = (slot_q[0] != slot_q[1]);
        vote_fault = vote_err || tmr_q;
      end
      default: begin
        vote_err   = 1'b1;
        vote_fault = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    data_o  = '0;
    id_o    = '0;
    error_o = 1'b0;
    lock_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_i == 2'd0) begin
          data_o  = data_i;
          id_o    = id_i;
          valid_o = valid_i;
          ready_o = ready_i;
        end else begin
          ready_o = 1'b1;
          if (valid_i) state_d = COLLECT;
        end
      end
      COLLECT: begin
        lock_o  = 1'b1;
        ready_o = !(valid_i && !id_match);
        if (valid_i) begin
          if (!id_match || (cnt_q + 2'd1 == n_req)) state_d = VOTE;
        end else if (wd_expire) begin
          state_d = VOTE;
          lock_o  = 1'b0;
        end
      end
      VOTE: begin
        valid_o = 1'b1;
        data_o  = vote_data;
        id_o    = grp_id_q;
        error_o = vote_err;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fault_detected_o = (state_q == VOTE) && !voted_q && vote_fault;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      wd_q          <= '0;
      mode_q        <= 2'd2;
      grp_id_q      <= '0;
      voted_q       <= 1'b0;
      fault_count_o <= '0;
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      voted_q <= (state_q == VOTE) && (state_d == VOTE);
      case (state_q)
        IDLE: begin
          if (mode_i != 2'd0 && valid_i) begin
            slot_q[0] <= data_i;
            grp_id_q  <= id_i;
            mode_q    <= mode_i;
            cnt_q     <= 2'd1;
            wd_q      <= '0;
          end
        end
        COLLECT: begin
          if (valid_i && id_match) begin
            slot_q[cnt_q] <= data_i;
            cnt_q         <= cnt_q + 2'd1;
            wd_q          <= '0;
          end else if (!valid_i) begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        VOTE: begin
          if (ready_i) begin
            cnt_q <= 2'd0;
            wd_q  <= '0;
          end
        end
        default: ;
      endcase
      if (fault_count_clear_i) begin
        fault_count_o <= '0;
      end else if (fault_detected_o && fault_count_o != '1) begin
        fault_count_o <= fault_count_o + CounterWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_time_nmr_end.sv
// tb/tb_time_nmr_end.sv - directed self-checking bench for time_nmr_end
module tb_time_nmr_end;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] mode_i;
  logic [7:0] data_i;
  logic [0:0] id_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic [0:0] id_o;
  logic       valid_o;
  logic       ready_i;
  logic       error_o;
  logic       lock_o;
  logic       fault_detected_o;
  logic [7:0] fault_count_o;
  logic       fault_count_clear_i;

  int checks = 0;
  int errors = 0;
  int pulses;

  time_nmr_end #(
    .DataType    (logic [7:0]),
    .IDSize      (1),
    .LockTimeout (4),
    .CounterWidth(8)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .mode_i             (mode_i),
    .data_i             (data_i),
    .id_i               (id_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .data_o             (data_o),
    .id_o               (id_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .error_o            (error_o),
    .lock_o             (lock_o),
    .fault_detected_o   (fault_detected_o),
    .fault_count_o      (fault_count_o),
    .fault_count_clear_i(fault_count_clear_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Present one replica for exactly one rising edge; returns at the following falling edge.
  task automatic put(input logic [7:0] d, input logic [0:0] id);
    valid_i = 1'b1;
    data_i  = d;
    id_i    = id;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    mode_i = 2'd2;
    data_i = 8'h00;
    id_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    fault_count_clear_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_count", fault_count_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_fault", fault_detected_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // TMR clean
    put(8'hA5, 0);
    chk("tmr_lock", lock_o, 1);
    put(8'hA5, 0);
    put(8'hA5, 0);
    chk("tmr_valid", valid_o, 1);
    chk("tmr_data", data_o, 8'hA5);
    chk("tmr_err", error_o, 0);
    chk("tmr_fd", fault_detected_o, 0);
    chk("tmr_lock_vote", lock_o, 0);
    @(negedge clk_i);
    chk("tmr_valid_done", valid_o, 0);
    chk("tmr_count", fault_count_o, 0);

    // TMR single fault with back-pressure
    ready_i = 1'b0;
    put(8'hA5, 0);
    put(8'h5A, 0);
    put(8'hA5, 0);
    chk("tmr1_data", data_o, 8'hA5);
    chk("tmr1_err", error_o, 0);
    chk("tmr1_fd", fault_detected_o, 1);
    pulses = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      pulses += int'(fault_detected_o);
      chk("tmr1_hold_data", data_o, 8'hA5);
      chk("tmr1_hold_valid", valid_o, 1);
    end
    chk("tmr1_pulses", pulses, 1);
    chk("tmr1_count", fault_count_o, 1);
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("tmr1_done", valid_o, 0);

    // DMR mismatch then clean
    mode_i = 2'd1;
    put(8'h11, 0);
    put(8'h12, 0);
    chk("dmr_data", data_o, 8'h11);
    chk("dmr_err", error_o, 1);
    chk("dmr_fd", fault_detected_o, 1);
    @(negedge clk_i);
    chk("dmr_count", fault_count_o, 2);
    put(8'h11, 0);
    put(8'h11, 0);
    chk("dmr_clean_valid", valid_o, 1);
    chk("dmr_clean_err", error_o, 0);
    chk("dmr_clean_fd", fault_detected_o, 0);
    @(negedge clk_i);
    chk("dmr_clean_count", fault_count_o, 2);

    // TMR group closed by an ID change
    mode_i = 2'd2;
    put(8'h33, 0);
    put(8'h33, 0);
    valid_i = 1'b1;
    data_i = 8'h44;
    id_i = 1'b1;
    #1;
    chk("idchg_ready", ready_o, 0);
    @(negedge clk_i);
    chk("idchg_valid", valid_o, 1);
    chk("idchg_data", data_o, 8'h33);
    chk("idchg_id", id_o, 0);
    chk("idchg_err", error_o, 0);
    chk("idchg_fd", fault_detected_o, 1);
    chk("idchg_vote_ready", ready_o, 0);
    @(negedge clk_i);
    chk("idchg_idle_ready", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("idchg_next_lock", lock_o, 1);
    put(8'h44, 1);
    put(8'h44, 1);
    chk("idchg_next_data", data_o, 8'h44);
    chk("idchg_next_id", id_o, 1);
    chk("idchg_next_err", error_o, 0);
    chk("idchg_next_fd", fault_detected_o, 0);
    @(negedge clk_i);
    chk("idchg_count", fault_count_o, 3);

    // Watchdog timeout with a single copy
    put(8'h77, 0);
    chk("wd_lock1", lock_o, 1);
    @(negedge clk_i);
    chk("wd_lock2", lock_o, 1);
    @(negedge clk_i);
    chk("wd_lock3", lock_o, 1);
    @(negedge clk_i);
    chk("wd_lock4", lock_o, 0);
    chk("wd_valid4", valid_o, 0);
    @(negedge clk_i);
    chk("wd_valid", valid_o, 1);
    chk("wd_data", data_o, 8'h77);
    chk("wd_err", error_o, 1);
    chk("wd_fd", fault_detected_o, 1);
    @(negedge clk_i);
    chk("wd_count", fault_count_o, 4);

    // Bypass
    mode_i = 2'd0;
    data_i = 8'h3C;
    id_i = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    #1;
    chk("byp_data", data_o, 8'h3C);
    chk("byp_id", id_o, 1);
    chk("byp_valid", valid_o, 1);
    chk("byp_ready0", ready_o, 0);
    chk("byp_lock", lock_o, 0);
    ready_i = 1'b1;
    #1;
    chk("byp_ready1", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("byp_count", fault_count_o, 4);

    // Saturation and clear-over-increment
    mode_i = 2'd1;
    for (int i = 0; i < 251; i++) begin
      put(8'h01, 0);
      put(8'h02, 0);
      @(negedge clk_i);
    end
    chk("sat_reach", fault_count_o, 8'hFF);
    put(8'h01, 0);
    put(8'h02, 0);
    @(negedge clk_i);
    chk("sat_hold", fault_count_o, 8'hFF);
    put(8'h01, 0);
    put(8'h02, 0);
    chk("clr_fd", fault_detected_o, 1);
    fault_count_clear_i = 1'b1;
    @(negedge clk_i);
    fault_count_clear_i = 1'b0;
    chk("clr_count", fault_count_o, 0);

    // Asynchronous reset during COLLECT
    mode_i = 2'd2;
    put(8'h09, 0);
    chk("arst_pre_lock", lock_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_lock", lock_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_count", fault_count_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
